// File: rtl/io_port_bank.sv
// Memory-mapped I/O register bank: debounced buttons with sticky press flags and
// a maskable interrupt, synchronised switches, and red/green LED registers.
module io_port_bank #(
    parameter int DATA_W         = 16,
    parameter int N_BTN          = 4,
    parameter int N_SW           = 10,
    parameter int N_LEDR         = 10,
    parameter int N_LEDG         = 8,
    parameter int DEBOUNCE       = 4,
    parameter bit BTN_ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [2:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic [N_BTN-1:0]  buttons,
    input  logic [N_SW-1:0]   switches,
    output logic [N_LEDR-1:0] led_r,
    output logic [N_LEDG-1:0] led_g,
    output logic              irq
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);

    localparam logic [2:0] A_BTN   = 3'd0;
    localparam logic [2:0] A_PEND  = 3'd1;
    localparam logic [2:0] A_SW    = 3'd2;
    localparam logic [2:0] A_LEDR  = 3'd3;
    localparam logic [2:0] A_LEDG  = 3'd4;
    localparam logic [2:0] A_IRQEN = 3'd5;

    // Bus protocol: no handshake. A write with we=1 completes at the rising edge;
    // reads are combinational from addr and never stall or side-effect.

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_sync1, btn_sync2;
    logic [N_BTN-1:0] deb, deb_next, rise;
    logic [CNT_W-1:0] cnt [N_BTN];
    logic [CNT_W-1:0] cnt_next [N_BTN];
    logic [N_BTN-1:0] pend, pend_next, irq_en, w1c;
    logic [N_SW-1:0]  sw_sync1, sw_sync2;
    logic             unused_wdata;

    // Inversion happens before the synchroniser so reset value 0 is always "released".
    assign btn_raw = BTN_ACTIVE_LOW ? ~buttons : buttons;

    always_comb begin
        deb_next = deb;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_next[i] = '0;
            if (btn_sync2[i] != deb[i]) begin
                if (cnt[i] == DEB_LAST)
                    deb_next[i] = ~deb[i];
                else
                    cnt_next[i] = cnt[i] + CNT_W'(1);
            end
        end
        rise = deb_next & ~deb;
    end

    // A press landing on the same edge as a W1C survives the clear.
    assign w1c       = (we && addr == A_PEND) ? wdata[N_BTN-1:0] : '0;
    assign pend_next = (pend & ~w1c) | rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_sync1 <= '0;
            btn_sync2 <= '0;
            deb       <= '0;
            pend      <= '0;
            sw_sync1  <= '0;
            sw_sync2  <= '0;
            for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
        end else begin
            btn_sync1 <= btn_raw;
            btn_sync2 <= btn_sync1;
            deb       <= deb_next;
            pend      <= pend_next;
            sw_sync1  <= switches;
            sw_sync2  <= sw_sync1;
            for (int i = 0; i < N_BTN; i++) cnt[i] <= cnt_next[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_r  <= '0;
            led_g  <= '0;
            irq_en <= '0;
        end else if (we) begin
            case (addr)
                A_LEDR:  led_r  <= wdata[N_LEDR-1:0];
                A_LEDG:  led_g  <= wdata[N_LEDG-1:0];
                A_IRQEN: irq_en <= wdata[N_BTN-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            A_BTN:   rdata[N_BTN-1:0]  = deb;
            A_PEND:  rdata[N_BTN-1:0]  = pend;
            A_SW:    rdata[N_SW-1:0]   = sw_sync2;
            A_LEDR:  rdata[N_LEDR-1:0] = led_r;
            A_LEDG:  rdata[N_LEDG-1:0] = led_g;
            A_IRQEN: rdata[N_BTN-1:0]  = irq_en;
            default: ;
        endcase
    end

    assign irq = |(pend & irq_en);

    // Upper write-data bits beyond each field width are intentionally dropped.
    assign unused_wdata = &{1'b0, wdata};

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank: an active-high instance for the main register
// behaviour and an active-low instance for button inversion.
module tb_io_port_bank;

    logic        clk;
    logic        reset;
    logic        we;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [3:0]  buttons;
    logic [9:0]  switches;
    logic [9:0]  led_r;
    logic [7:0]  led_g;
    logic        irq;

    logic [2:0]  al_addr;
    logic [15:0] al_rdata;
    logic [3:0]  al_buttons;
    logic [9:0]  al_led_r;
    logic [7:0]  al_led_g;
    logic        al_irq;

    int n_vec = 0;
    int n_err = 0;

    io_port_bank #(
        .DATA_W(16), .N_BTN(4), .N_SW(10), .N_LEDR(10), .N_LEDG(8),
        .DEBOUNCE(4), .BTN_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .buttons(buttons), .switches(switches),
        .led_r(led_r), .led_g(led_g), .irq(irq)
    );

    io_port_bank #(
        .DATA_W(16), .N_BTN(4), .N_SW(10), .N_LEDR(10), .N_LEDG(8),
        .DEBOUNCE(4), .BTN_ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .reset(reset), .we(1'b0), .addr(al_addr), .wdata(16'h0000),
        .rdata(al_rdata), .buttons(al_buttons), .switches(10'h000),
        .led_r(al_led_r), .led_g(al_led_g), .irq(al_irq)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: every task leaves time at 1 ns after a rising edge or later in the cycle.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic rd_al(input logic [2:0] a, input logic [15:0] exp, input string tag);
        al_addr = a;
        #1;
        chk(tag, al_rdata, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        we    = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        we         = 1'b0;
        addr       = 3'd0;
        wdata      = 16'h0000;
        buttons    = 4'h0;
        switches   = 10'h000;
        al_addr    = 3'd0;
        al_buttons = 4'hF;
        tick(2);

        // Reset state
        rd(3'd0, 16'h0000, "rst_btn");
        rd(3'd1, 16'h0000, "rst_pend");
        rd(3'd2, 16'h0000, "rst_sw");
        rd(3'd5, 16'h0000, "rst_irqen");
        chk("rst_led_r", {6'h0, led_r}, 16'h0000);
        chk("rst_led_g", {8'h0, led_g}, 16'h0000);
        chk("rst_irq", {15'h0, irq}, 16'h0000);
        tick(1);
        reset = 1'b0;

        // Load state, then assert reset mid-cycle and expect everything cleared at once
        wr(3'd3, 16'h03FF);
        wr(3'd4, 16'h00FF);
        wr(3'd5, 16'h000F);
        buttons = 4'hF;
        tick(6);
        rd(3'd1, 16'h000F, "pre_rst_pend");
        chk("pre_rst_irq", {15'h0, irq}, 16'h0001);
        #2;
        reset = 1'b1;
        #1;
        chk("async_led_r", {6'h0, led_r}, 16'h0000);
        chk("async_led_g", {8'h0, led_g}, 16'h0000);
        chk("async_irq", {15'h0, irq}, 16'h0000);
        rd(3'd0, 16'h0000, "async_btn");
        rd(3'd1, 16'h0000, "async_pend");
        rd(3'd5, 16'h0000, "async_irqen");
        tick(1);
        reset = 1'b0;

        // Buttons held high through release: level and flags appear on edge 6
        tick(5);
        rd(3'd0, 16'h0000, "rel_btn_e5");
        rd(3'd1, 16'h0000, "rel_pend_e5");
        tick(1);
        rd(3'd0, 16'h000F, "rel_btn_e6");
        rd(3'd1, 16'h000F, "rel_pend_e6");
        chk("rel_irq_masked", {15'h0, irq}, 16'h0000);

        buttons = 4'h0;
        tick(6);
        rd(3'd0, 16'h0000, "release_btn");
        wr(3'd1, 16'h000F);
        rd(3'd1, 16'h0000, "w1c_all");

        // 3-cycle glitch on button 1 is filtered
        buttons = 4'h2;
        tick(3);
        buttons = 4'h0;
        tick(10);
        rd(3'd0, 16'h0000, "glitch_btn");
        rd(3'd1, 16'h0000, "glitch_pend");

        // Held press on button 1
        buttons = 4'h2;
        tick(5);
        rd(3'd0, 16'h0000, "hold_btn_e5");
        tick(1);
        rd(3'd0, 16'h0002, "hold_btn_e6");
        rd(3'd1, 16'h0002, "hold_pend_e6");
        tick(4);
        buttons = 4'h0;
        tick(6);
        rd(3'd0, 16'h0000, "unpress_btn");
        rd(3'd1, 16'h0002, "unpress_pend");

        // Build PEND=3 with button 0 released again
        buttons = 4'h1;
        tick(6);
        rd(3'd1, 16'h0003, "pend3");
        buttons = 4'h0;
        tick(6);
        rd(3'd0, 16'h0000, "b0_released");

        // W1C of 0x3 on the edge button 0 debounces high: set wins for bit 0
        buttons = 4'h1;
        tick(5);
        wr(3'd1, 16'h0003);
        rd(3'd1, 16'h0001, "race_pend");
        rd(3'd0, 16'h0001, "race_btn");
        wr(3'd1, 16'h0001);
        rd(3'd1, 16'h0000, "race_clear");
        buttons = 4'h0;
        tick(6);

        // Interrupt masking
        buttons = 4'h4;
        tick(6);
        buttons = 4'h0;
        tick(6);
        rd(3'd1, 16'h0004, "irq_pend4");
        chk("irq_masked", {15'h0, irq}, 16'h0000);
        wr(3'd5, 16'h0004);
        chk("irq_enabled", {15'h0, irq}, 16'h0001);
        rd(3'd5, 16'h0004, "irqen_rd");
        wr(3'd1, 16'h0004);
        chk("irq_w1c", {15'h0, irq}, 16'h0000);
        buttons = 4'h4;
        tick(5);
        chk("irq_press_e5", {15'h0, irq}, 16'h0000);
        tick(1);
        chk("irq_press_e6", {15'h0, irq}, 16'h0001);
        wr(3'd1, 16'h0004);
        chk("irq_w1c_held", {15'h0, irq}, 16'h0000);
        buttons = 4'h0;
        tick(6);

        // LEDs and switches
        wr(3'd3, 16'hFFFF);
        chk("led_r_out", {6'h0, led_r}, 16'h03FF);
        rd(3'd3, 16'h03FF, "ledr_rd");
        wr(3'd4, 16'h00A5);
        chk("led_g_out", {8'h0, led_g}, 16'h00A5);
        rd(3'd4, 16'h00A5, "ledg_rd");
        switches = 10'h155;
        tick(1);
        rd(3'd2, 16'h0000, "sw_e1");
        tick(1);
        rd(3'd2, 16'h0155, "sw_e2");
        wr(3'd2, 16'hFFFF);
        rd(3'd2, 16'h0155, "sw_ro");
        wr(3'd0, 16'hFFFF);
        rd(3'd0, 16'h0000, "btn_ro");

        // Unmapped addresses
        wr(3'd7, 16'hFFFF);
        wr(3'd6, 16'h1234);
        rd(3'd7, 16'h0000, "addr7");
        rd(3'd6, 16'h0000, "addr6");
        chk("unmapped_led_r", {6'h0, led_r}, 16'h03FF);
        chk("unmapped_led_g", {8'h0, led_g}, 16'h00A5);
        rd(3'd5, 16'h0004, "unmapped_irqen");

        // Active-low instance: buttons held 1111 since reset means nothing pressed
        rd_al(3'd0, 16'h0000, "al_btn_idle");
        rd_al(3'd1, 16'h0000, "al_pend_idle");
        chk("al_irq", {15'h0, al_irq}, 16'h0000);
        al_buttons = 4'hE;
        tick(6);
        rd_al(3'd0, 16'h0001, "al_btn_press");
        rd_al(3'd1, 16'h0001, "al_pend_press");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
